// File: rtl/alu_issue_seq_if.sv
// Bundle of the instruction, load, ALU and result channels of alu_issue_seq.
// slave = sequencer side, master = surrounding datapath / environment.
interface alu_issue_seq_if #(
   parameter int DATA_W = 8,
   parameter int NREG_W = 3
);
   localparam int INSTR_W = 3 + 2 * NREG_W;

   // Handshakes (instr, ld, res): a transfer happens on the rising edge where
   // valid & ready are both 1; valid may drop without a transfer taking place.
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;

   logic               ld_valid;
   logic [NREG_W-1:0]  ld_addr;
   logic [DATA_W-1:0]  ld_data;
   logic               ld_ready;

   logic [2:0]         alu_op;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [DATA_W-1:0]  alu_out;
   logic               alu_zero;

   logic [DATA_W-1:0]  res_data;
   logic               res_zero;
   logic               res_valid;
   logic               res_ready;

   modport slave (
      input  instr, instr_valid, ld_valid, ld_addr, ld_data,
             alu_out, alu_zero, res_ready,
      output instr_ready, ld_ready, alu_op, alu_a, alu_b,
             res_data, res_zero, res_valid
   );

   modport master (
      output instr, instr_valid, ld_valid, ld_addr, ld_data,
             alu_out, alu_zero, res_ready,
      input  instr_ready, ld_ready, alu_op, alu_a, alu_b,
             res_data, res_zero, res_valid
   );
endinterface

// File: rtl/alu_issue_seq.sv
// Serial issue sequencer for the combinational ALU: IDLE -> ISSUE -> CAPT -> RESP.
// Optional retirement counter port retire_cnt when ISSUE_RETIRE_CNT_EN is defined.
module alu_issue_seq #(
   parameter int DATA_W = 8,
   parameter int NREG_W = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   alu_issue_seq_if.slave bus,
   output logic [1:0]     state_dbg
`ifdef ISSUE_RETIRE_CNT_EN
   ,
   output logic [15:0]    retire_cnt
`endif
);

   localparam int INSTR_W = 3 + 2 * NREG_W;
   localparam int NREG    = 1 << NREG_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] CAPT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [2:0] OP_PAR = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;
   localparam logic [2:0] OP_MOV = 3'b111;

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [DATA_W-1:0] regs [NREG];
   logic [2:0]        op_q;
   logic [NREG_W-1:0] ra_q;

   logic [2:0]        op_in;
   logic [NREG_W-1:0] ra_in;
   logic [NREG_W-1:0] rb_in;
   logic              instr_acc;
   logic              ld_acc;
   logic              wb_en;

   assign op_in = bus.instr[INSTR_W-1 -: 3];
   assign ra_in = bus.instr[2*NREG_W-1 -: NREG_W];
   assign rb_in = bus.instr[NREG_W-1:0];

   // Ready is gated by reset_n so nothing is advertised while reset is held.
   assign bus.ld_ready    = reset_n & (state == IDLE);
   assign bus.instr_ready = reset_n & (state == IDLE) & ~bus.ld_valid;
   assign bus.res_valid   = (state == RESP);
   assign state_dbg       = state;

   assign instr_acc = bus.instr_valid & bus.instr_ready;
   assign ld_acc    = bus.ld_valid & bus.ld_ready;
   assign wb_en     = (state == CAPT) && (op_q != OP_CMP) && (op_q != OP_PAR);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (instr_acc) state_nx = ISSUE;
         ISSUE:   state_nx = CAPT;
         CAPT:    state_nx = RESP;
         RESP:    if (bus.res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operands are latched at the accept edge so they are stable for all of ISSUE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.alu_op <= '0;
         bus.alu_a  <= '0;
         bus.alu_b  <= '0;
         op_q       <= '0;
         ra_q       <= '0;
      end else if (instr_acc) begin
         bus.alu_op <= op_in;
         op_q       <= op_in;
         ra_q       <= ra_in;
         if (op_in == OP_MOV) begin
            bus.alu_a <= regs[rb_in];
            bus.alu_b <= '0;
         end else begin
            bus.alu_a <= regs[ra_in];
            bus.alu_b <= regs[rb_in];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.res_data <= '0;
         bus.res_zero <= 1'b0;
      end else if (state == CAPT) begin
         bus.res_data <= bus.alu_out;
         bus.res_zero <= bus.alu_zero;
      end
   end

   // Loads only happen in IDLE and writeback only in CAPT, so they never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (ld_acc) begin
         regs[bus.ld_addr] <= bus.ld_data;
      end else if (wb_en) begin
         regs[ra_q] <= bus.alu_out;
      end
   end

`ifdef ISSUE_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retire_cnt <= '0;
      end else if (bus.res_valid && bus.res_ready) begin
         retire_cnt <= retire_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural stand-in for the ALU.
module tb_alu_issue_seq;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct {
    logic [8:0] ins;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] state_dbg;
  logic [7:0] alu_res;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         retired = 0;
  logic [7:0] exp_q[$];
  vec_t       vecs[16];
  vec_t       v;

  alu_issue_seq_if #(.DATA_W(8), .NREG_W(3)) bus ();

`ifdef ISSUE_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  alu_issue_seq #(.DATA_W(8), .NREG_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef ISSUE_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // ALU stand-in: 0 add, 1 sub, 2 shl, 3 parity, 4 cmp(a<b), 5 and, 6 or, 7 pass a
  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_op)
      3'd0: alu_res = bus.alu_a + bus.alu_b;
      3'd1: alu_res = bus.alu_a - bus.alu_b;
      3'd2: alu_res = (bus.alu_b >= 8'd8) ? 8'h00 : (bus.alu_a << bus.alu_b[2:0]);
      3'd3: alu_res = {7'b0, ^bus.alu_a};
      3'd4: alu_res = {7'b0, (bus.alu_a < bus.alu_b)};
      3'd5: alu_res = bus.alu_a & bus.alu_b;
      3'd6: alu_res = bus.alu_a | bus.alu_b;
      default: alu_res = bus.alu_a;
    endcase
    bus.alu_out  = alu_res;
    bus.alu_zero = (alu_res == 8'h00);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // driver tasks
  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    int n = 0;
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    while (!bus.ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ld_ready) timeout_fail("ld_timeout");
    @(posedge clk);
    #1 bus.ld_valid = 1'b0;
  endtask

  // Issues one instruction, checks ISSUE outputs, returns at a negedge in RESP.
  task automatic to_resp(input string name, input logic [8:0] ins,
                         input logic [7:0] ea, input logic [7:0] eb);
    int n = 0;
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      bus.instr_valid = 1'b0;
      timeout_fail({name, "_accept"});
      return;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    check({name, "_state_issue"}, {14'b0, state_dbg}, {14'b0, S_ISSUE});
    check({name, "_alu_op"}, {13'b0, bus.alu_op}, {13'b0, ins[8:6]});
    check({name, "_alu_a"}, {8'b0, bus.alu_a}, {8'b0, ea});
    check({name, "_alu_b"}, {8'b0, bus.alu_b}, {8'b0, eb});
    n = 0;
    while (!bus.res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) timeout_fail({name, "_res_valid"});
  endtask

  task automatic take_resp(input string name, input logic ez);
    logic [7:0] exp_d;
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({name, "_res_data"}, {8'b0, bus.res_data}, {8'b0, exp_d});
    check({name, "_res_zero"}, {15'b0, bus.res_zero}, {15'b0, ez});
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    retired++;
  endtask

  task automatic run_vec(input string name, input vec_t vv);
    exp_q.push_back(vv.res);
    to_resp(name, vv.ins, vv.a, vv.b);
    take_resp(name, vv.z);
  endtask

  initial begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.res_ready   = 1'b0;

    vecs[0]  = '{9'b000_001_010, 8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1]  = '{9'b001_011_011, 8'h7F, 8'h7F, 8'h00, 1'b1};
    vecs[2]  = '{9'b100_100_101, 8'hF8, 8'hFF, 8'h01, 1'b0};
    vecs[3]  = '{9'b100_001_001, 8'h08, 8'h08, 8'h00, 1'b1};
    vecs[4]  = '{9'b100_011_011, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{9'b100_100_100, 8'hF8, 8'hF8, 8'h00, 1'b1};
    vecs[6]  = '{9'b000_101_000, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[7]  = '{9'b011_100_010, 8'hF8, 8'h03, 8'h01, 1'b0};
    vecs[8]  = '{9'b100_100_010, 8'hF8, 8'h03, 8'h00, 1'b1};
    vecs[9]  = '{9'b010_010_100, 8'h03, 8'hF8, 8'h00, 1'b1};
    vecs[10] = '{9'b010_001_000, 8'h08, 8'h01, 8'h10, 1'b0};
    vecs[11] = '{9'b100_010_101, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{9'b101_001_001, 8'h10, 8'h10, 8'h10, 1'b0};
    vecs[13] = '{9'b110_000_001, 8'h01, 8'h10, 8'h11, 1'b0};
    vecs[14] = '{9'b111_111_000, 8'h11, 8'h00, 8'h11, 1'b0};
    vecs[15] = '{9'b100_111_111, 8'h11, 8'h11, 8'h00, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_instr_ready", {15'b0, bus.instr_ready}, 16'h0);
    check("rst_ld_ready", {15'b0, bus.ld_ready}, 16'h0);
    check("rst_res_valid", {15'b0, bus.res_valid}, 16'h0);
    check("rst_state", {14'b0, state_dbg}, {14'b0, S_IDLE});
    check("rst_alu_a", {8'b0, bus.alu_a}, 16'h0);
    check("rst_res_data", {8'b0, bus.res_data}, 16'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ld_ready", {15'b0, bus.ld_ready}, 16'h1);
    check("idle_instr_ready", {15'b0, bus.instr_ready}, 16'h1);

    do_load(3'd0, 8'h01);
    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    do_load(3'd3, 8'h7F);
    do_load(3'd4, 8'hF8);
    do_load(3'd5, 8'hFF);

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      run_vec($sformatf("vec%0d", i), v);
    end

    // load wins over a same-cycle instruction; MOV then sees the new R1
    @(negedge clk);
    bus.ld_valid    = 1'b1;
    bus.ld_addr     = 3'd1;
    bus.ld_data     = 8'h5A;
    bus.instr       = 9'b111_110_001;
    bus.instr_valid = 1'b1;
    #1;
    check("prio_instr_ready", {15'b0, bus.instr_ready}, 16'h0);
    check("prio_ld_ready", {15'b0, bus.ld_ready}, 16'h1);
    @(posedge clk);
    #1 bus.ld_valid = 1'b0;
    @(negedge clk);
    check("prio_state_idle", {14'b0, state_dbg}, {14'b0, S_IDLE});
    check("prio_instr_ready2", {15'b0, bus.instr_ready}, 16'h1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    check("mov_state", {14'b0, state_dbg}, {14'b0, S_ISSUE});
    check("mov_alu_op", {13'b0, bus.alu_op}, 16'h7);
    check("mov_alu_a", {8'b0, bus.alu_a}, 16'h5A);
    check("mov_alu_b", {8'b0, bus.alu_b}, 16'h0);
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h5A);
    take_resp("mov", 1'b0);

    // result held while res_ready stays low; a pending instruction is refused
    exp_q.push_back(8'h00);
    to_resp("hold", 9'b100_110_110, 8'h5A, 8'h5A);
    bus.instr       = 9'b000_000_000;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), {15'b0, bus.res_valid}, 16'h1);
      check($sformatf("hold%0d_data", i), {8'b0, bus.res_data}, 16'h00);
      check($sformatf("hold%0d_instr_ready", i), {15'b0, bus.instr_ready}, 16'h0);
      @(negedge clk);
    end
    check("hold_state", {14'b0, state_dbg}, {14'b0, S_RESP});
    bus.instr_valid = 1'b0;
    take_resp("hold", 1'b1);

`ifdef ISSUE_RETIRE_CNT_EN
    @(negedge clk);
    check("retire_cnt", retire_cnt, retired[15:0]);
`endif

    // reset while a result is pending
    to_resp("midrst", 9'b000_111_111, 8'h11, 8'h11);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_res_valid", {15'b0, bus.res_valid}, 16'h0);
    check("midrst_ld_ready", {15'b0, bus.ld_ready}, 16'h0);
    check("midrst_instr_ready", {15'b0, bus.instr_ready}, 16'h0);
    check("midrst_res_data", {8'b0, bus.res_data}, 16'h0);
    retired = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      v.ins = {3'b100, r[2:0], r[2:0]};
      v.a   = 8'h00;
      v.b   = 8'h00;
      v.res = 8'h00;
      v.z   = 1'b1;
      run_vec($sformatf("zero_r%0d", r), v);
    end

`ifdef ISSUE_RETIRE_CNT_EN
    @(negedge clk);
    check("retire_cnt_after_rst", retire_cnt, retired[15:0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
